// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Serial boot loader for the instruction memory.
//
// A session begins with a one-cycle start pulse. It then receives:
//   1. an 8-bit header holding the word count N (0 means 256),
//   2. N instruction words of INSTR_W bits, MSB first, and
//   3. an INSTR_W-bit checksum, which must equal the XOR of all the words.
// Each assembled word is written to memory in a single WR cycle.
// The processor is held in reset (core_hold) until a session ends with a
// good checksum.
//
// Serial handshake:
//   A bit moves across the interface on a rising edge where both
//   sin_valid and sin_ready are 1. sin_ready depends only on the FSM state
//   and never on sin_valid. A bit offered while sin_ready is 0 is dropped.
//   The sender keeps offering the same bit until it has been accepted.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle pulse that begins a session (ignored while busy)
//   sin_valid  in   a serial bit is offered this cycle
//   sin_bit    in   serial data bit, MSB first
//   sin_ready  out  loader accepts a bit this cycle (HDR, DATA, CHK)
//   mem_we     out  instruction-memory write strobe (WR only)
//   mem_adr    out  write address (current word index)
//   mem_wd     out  write data (assembled word)
//   core_hold  out  holds the processor in reset while 1
//   busy       out  session in progress
//   done       out  last session completed with a good checksum
//   err        out  last session aborted (bad checksum or timeout)
//   dbg_state  out  current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADR_W   = 8,
  parameter int INSTR_W = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sin_valid,
  input  logic               sin_bit,
  output logic               sin_ready,
  output logic               mem_we,
  output logic [ADR_W-1:0]   mem_adr,
  output logic [INSTR_W-1:0] mem_wd,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  // The bit counter must reach the larger of the header width and the word width.
  localparam int BC_MAX = (INSTR_W > 8) ? INSTR_W : 8;
  localparam int BC_W   = $clog2(BC_MAX + 1);
  localparam int TM_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_WR   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q,   cnt_d;    // header word count N
  logic [INSTR_W-1:0] shift_q, shift_d;  // data / checksum shift register
  logic [BC_W-1:0]    bit_q,   bit_d;    // accepted bits in the current field
  logic [ADR_W-1:0]   idx_q,   idx_d;    // word index and write address
  logic [INSTR_W-1:0] xor_q,   xor_d;    // running XOR of the written words
  logic [TM_W-1:0]    tmo_q,   tmo_d;    // idle cycles since the last accepted bit

  logic               accept;
  logic [INSTR_W-1:0] shift_in;
  logic [TM_W-1:0]    tmo_inc;
  logic [7:0]         idx_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
    end
  end

  assign sin_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept    = sin_valid & sin_ready;
  assign shift_in  = {shift_q[INSTR_W-2:0], sin_bit};
  assign tmo_inc   = tmo_q + TM_W'(1);
  // The word count is modulo 256, so the index is compared on 8 bits only.
  assign idx_lo    = 8'(idx_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          shift_d = '0;
          bit_d   = '0;
          idx_d   = '0;
          xor_d   = '0;
          tmo_d   = '0;
        end
      end

      S_HDR: begin
        if (accept) begin
          cnt_d = {cnt_q[6:0], sin_bit};
          tmo_d = '0;
          if (bit_q == BC_W'(7)) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d = shift_in;
          tmo_d   = '0;
          if (bit_q == BC_W'(INSTR_W - 1)) begin
            bit_d   = '0;
            state_d = S_WR;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end

      S_WR: begin
        xor_d   = xor_q ^ shift_q;
        idx_d   = idx_q + ADR_W'(1);
        tmo_d   = '0;
        // A header of 0 wraps to 255 here, which gives 256 words.
        state_d = (idx_lo == (cnt_q - 8'd1)) ? S_CHK : S_DATA;
      end

      S_CHK: begin
        if (accept) begin
          shift_d = shift_in;
          tmo_d   = '0;
          if (bit_q == BC_W'(INSTR_W - 1)) begin
            bit_d   = '0;
            state_d = (shift_in == xor_q) ? S_DONE : S_ERR;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Timeout applies to every bit-receiving state. sin_ready is 1 exactly in those states.
    if (sin_ready && !accept) begin
      tmo_d = tmo_inc;
      if (tmo_inc == TM_W'(TIMEOUT)) begin
        state_d = S_ERR;
      end
    end
  end

  assign mem_we    = (state_q == S_WR);
  assign mem_adr   = idx_q;
  assign mem_wd    = shift_q;
  assign busy      = sin_ready || (state_q == S_WR);
  assign core_hold = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign dbg_state = state_q;

endmodule
